// File: rtl/ctrl_edicion_campos_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_edicion_campos_pkg
//  Description : Shared types, sizes and field-edit helpers for the RTC
//                field-edit controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_edicion_campos_pkg;

    localparam int NUM_CAMPOS = 9;
    localparam int IDX_W      = 4;
    localparam int DATO_W     = 7;

    // Highest legal field index, in index width.
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_CAMPOS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2
    } estado_t;

    // Increment with wrap to 0 once the limit is reached (or exceeded).
    function automatic logic [DATO_W-1:0] f_inc(input logic [DATO_W-1:0] v,
                                                input logic [DATO_W-1:0] lim);
        return (v >= lim) ? '0 : v + DATO_W'(1);
    endfunction

    // Decrement with wrap to the limit; an out-of-range value snaps to the limit.
    function automatic logic [DATO_W-1:0] f_dec(input logic [DATO_W-1:0] v,
                                                input logic [DATO_W-1:0] lim);
        return ((v == '0) || (v > lim)) ? lim : v - DATO_W'(1);
    endfunction

    // Field index advance with wrap from the last field back to 0.
    function automatic logic [IDX_W-1:0] f_next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_MAX) ? '0 : i + IDX_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_edicion_campos_if.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_edicion_campos_if
//  Description : User-button, preload, limit-decoder and RTC write-path bus
//                of the field-edit controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ctrl_edicion_campos_if;
    import ctrl_edicion_campos_pkg::*;

    // User side
    logic              edit_req;
    logic              btn_sig;
    logic              btn_inc;
    logic              btn_dec;
    // Limit decoder
    logic [DATO_W-1:0] limite;
    logic [IDX_W-1:0]  campo_sel;
    logic              deco_en;
    // RTC read path preload
    logic              load_valid;
    logic [IDX_W-1:0]  load_idx;
    logic [DATO_W-1:0] load_data;
    // RTC write path
    logic              wr_req;
    logic [IDX_W-1:0]  wr_addr;
    logic [DATO_W-1:0] wr_data;
    logic              wr_ack;
    // Status
    logic [DATO_W-1:0] dato_actual;
    logic              edit_activo;
    logic              commit_done;

    // Controller view
    modport slave (
        input  edit_req, btn_sig, btn_inc, btn_dec, limite,
               load_valid, load_idx, load_data, wr_ack,
        output campo_sel, deco_en, wr_req, wr_addr, wr_data,
               dato_actual, edit_activo, commit_done
    );

    // Environment view
    modport master (
        output edit_req, btn_sig, btn_inc, btn_dec, limite,
               load_valid, load_idx, load_data, wr_ack,
        input  campo_sel, deco_en, wr_req, wr_addr, wr_data,
               dato_actual, edit_activo, commit_done
    );

endinterface
`default_nettype wire

// File: rtl/ctrl_edicion_campos_banco_campos.sv
`default_nettype none
// ============================================================================
//  Module      : banco_campos
//  Description : 9 x 7-bit field register bank, one synchronous write port
//                and two combinational read ports. Out-of-range addresses
//                read 0 and are never written.
//  Revision    : 1.0 - initial release
// ============================================================================
module banco_campos
    import ctrl_edicion_campos_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              we_i,
    input  wire logic [IDX_W-1:0]  waddr_i,
    input  wire logic [DATO_W-1:0] wdata_i,
    input  wire logic [IDX_W-1:0]  raddr_a_i,
    output logic      [DATO_W-1:0] rdata_a_o,
    input  wire logic [IDX_W-1:0]  raddr_b_i,
    output logic      [DATO_W-1:0] rdata_b_o
);

    logic [DATO_W-1:0] campos_q [NUM_CAMPOS];

    // Field storage: cleared on reset, single write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CAMPOS; i++) begin
                campos_q[i] <= '0;
            end
        end else if (we_i && (waddr_i <= IDX_MAX)) begin
            campos_q[waddr_i] <= wdata_i;
        end
    end

    // Two independent combinational read ports.
    always_comb begin
        rdata_a_o = (raddr_a_i <= IDX_MAX) ? campos_q[raddr_a_i] : '0;
        rdata_b_o = (raddr_b_i <= IDX_MAX) ? campos_q[raddr_b_i] : '0;
    end

endmodule
`default_nettype wire

// File: rtl/ctrl_edicion_campos.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_edicion_campos
//  Description : RTC field-edit controller. Preloads fields in IDLE, edits
//                them with next/inc/dec buttons against an external limit
//                decoder in EDIT, then writes all nine fields back through a
//                req/ack write path in COMMIT.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_edicion_campos
    import ctrl_edicion_campos_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              reset,
    ctrl_edicion_campos_if.slave   bus
);

    estado_t           estado_q, estado_d;
    logic [IDX_W-1:0]  sel_q, sel_d;
    logic [IDX_W-1:0]  widx_q, widx_d;
    logic              commit_done_q, commit_done_d;

    logic              w_we;
    logic [IDX_W-1:0]  w_waddr;
    logic [DATO_W-1:0] w_wdata;
    logic [DATO_W-1:0] w_campo_sel;
    logic [DATO_W-1:0] w_campo_wr;
    logic              w_ultimo_ack;

    // Last acknowledged write of the commit sweep.
    assign w_ultimo_ack = (estado_q == ST_COMMIT) && bus.wr_ack && (widx_q == IDX_MAX);

    banco_campos u_banco (
        .clk       (clk),
        .reset     (reset),
        .we_i      (w_we),
        .waddr_i   (w_waddr),
        .wdata_i   (w_wdata),
        .raddr_a_i (sel_q),
        .rdata_a_o (w_campo_sel),
        .raddr_b_i (widx_q),
        .rdata_b_o (w_campo_wr)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= ST_IDLE;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Next-state: edit_req is only looked at in IDLE and EDIT, so a request
    // raised during COMMIT waits until the sweep has finished.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            ST_IDLE:   if (bus.edit_req)  estado_d = ST_EDIT;
            ST_EDIT:   if (!bus.edit_req) estado_d = ST_COMMIT;
            ST_COMMIT: if (w_ultimo_ack)  estado_d = ST_IDLE;
            default:   estado_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs; write bus is held at 0 outside COMMIT.
    always_comb begin
        bus.edit_activo = 1'b0;
        bus.deco_en     = 1'b0;
        bus.wr_req      = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        case (estado_q)
            ST_EDIT: begin
                bus.edit_activo = 1'b1;
                bus.deco_en     = 1'b1;
            end
            ST_COMMIT: begin
                bus.wr_req  = 1'b1;
                bus.wr_addr = widx_q;
                bus.wr_data = w_campo_wr;
            end
            default: ;
        endcase
    end

    // Field write port: preload in IDLE, inc/dec edit in EDIT. Both buttons
    // together cancel out, so no write happens then.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = '0;
        case (estado_q)
            ST_IDLE: begin
                w_we    = bus.load_valid && (bus.load_idx <= IDX_MAX);
                w_waddr = bus.load_idx;
                w_wdata = bus.load_data;
            end
            ST_EDIT: begin
                w_we    = bus.btn_inc ^ bus.btn_dec;
                w_waddr = sel_q;
                w_wdata = bus.btn_inc ? f_inc(w_campo_sel, bus.limite)
                                      : f_dec(w_campo_sel, bus.limite);
            end
            default: ;
        endcase
    end

    // Index next-state: selected field moves only in EDIT, write index only
    // in COMMIT; both sit at 0 everywhere else so every entry starts at 0.
    always_comb begin
        sel_d         = '0;
        widx_d        = '0;
        commit_done_d = w_ultimo_ack;
        if (estado_q == ST_EDIT && bus.edit_req) begin
            sel_d = bus.btn_sig ? f_next_idx(sel_q) : sel_q;
        end
        if (estado_q == ST_COMMIT) begin
            widx_d = bus.wr_ack ? f_next_idx(widx_q) : widx_q;
        end
    end

    // Index and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q         <= '0;
            widx_q        <= '0;
            commit_done_q <= 1'b0;
        end else begin
            sel_q         <= sel_d;
            widx_q        <= widx_d;
            commit_done_q <= commit_done_d;
        end
    end

    assign bus.campo_sel   = sel_q;
    assign bus.dato_actual = w_campo_sel;
    assign bus.commit_done = commit_done_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_edicion_campos.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctrl_edicion_campos
//  Description : Scoreboard bench for ctrl_edicion_campos.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_edicion_campos;

    typedef struct {int sel; int dato; int edit; int wrq;} probe_t;
    typedef struct {int addr; int data;} wr_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic probe_stb = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int ack_seen = 0;
    int commit_seen = 0;
    int exp_f [9];

    probe_t probe_q [$];
    wr_t    wr_q    [$];
    int     commit_q[$];

    ctrl_edicion_campos_if bus_if ();

    ctrl_edicion_campos dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    // Monitor: pops and compares whenever the DUT presents something.
    always @(negedge clk) begin
        probe_t p;
        if (probe_stb) begin
            if (probe_q.size() == 0) begin
                chk("probe_queue", 0, 1);
            end else begin
                p = probe_q.pop_front();
                chk("campo_sel",   int'(bus_if.campo_sel),   p.sel);
                chk("dato_actual", int'(bus_if.dato_actual), p.dato);
                chk("edit_activo", int'(bus_if.edit_activo), p.edit);
                chk("deco_en",     int'(bus_if.deco_en),     p.edit);
                chk("wr_req",      int'(bus_if.wr_req),      p.wrq);
            end
        end
        if (bus_if.wr_req) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_wr_req", 1, 0);
            end else begin
                chk("wr_addr", int'(bus_if.wr_addr), wr_q[0].addr);
                chk("wr_data", int'(bus_if.wr_data), wr_q[0].data);
                if (bus_if.wr_ack) begin
                    void'(wr_q.pop_front());
                    ack_seen++;
                end
            end
        end
        if (bus_if.commit_done) begin
            chk("commit_done_expected", int'(commit_q.size() > 0), 1);
            if (commit_q.size() > 0) void'(commit_q.pop_front());
            commit_seen++;
        end
    end

    // Write-path responder: acknowledges each request after 3 wait cycles.
    initial begin
        int wcnt = 0;
        bus_if.wr_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus_if.wr_ack = 1'b0;
            if (!reset && bus_if.wr_req) begin
                wcnt++;
                if (wcnt == 4) begin
                    bus_if.wr_ack = 1'b1;
                    wcnt = 0;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic btn(input logic s, input logic i, input logic d);
        bus_if.btn_sig = s;
        bus_if.btn_inc = i;
        bus_if.btn_dec = d;
        cyc();
        bus_if.btn_sig = 1'b0;
        bus_if.btn_inc = 1'b0;
        bus_if.btn_dec = 1'b0;
    endtask

    task automatic probe(input int sel, input int dato, input int edit, input int wrq);
        probe_t p;
        p.sel = sel; p.dato = dato; p.edit = edit; p.wrq = wrq;
        probe_q.push_back(p);
        probe_stb = 1'b1;
        cyc();
        probe_stb = 1'b0;
    endtask

    task automatic load(input int idx, input int data);
        bus_if.load_valid = 1'b1;
        bus_if.load_idx   = 4'(idx);
        bus_if.load_data  = 7'(data);
        cyc();
        bus_if.load_valid = 1'b0;
    endtask

    task automatic push_writes(input int n);
        wr_t w;
        for (int i = 0; i < n; i++) begin
            w.addr = i;
            w.data = exp_f[i];
            wr_q.push_back(w);
        end
    endtask

    task automatic wait_commit();
        int start;
        bit seen;
        start = commit_seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            cyc();
            seen = (commit_seen > start);
        end
        chk("commit_timeout", int'(seen), 1);
    endtask

    initial begin
        int base;
        bit got;
        bus_if.edit_req   = 1'b0;
        bus_if.btn_sig    = 1'b0;
        bus_if.btn_inc    = 1'b0;
        bus_if.btn_dec    = 1'b0;
        bus_if.limite     = '0;
        bus_if.load_valid = 1'b0;
        bus_if.load_idx   = '0;
        bus_if.load_data  = '0;

        repeat (2) cyc();
        reset = 1'b0;
        probe(0, 0, 0, 0);

        // Preload; indices above 8 are dropped
        load(1, 58);
        load(2, 30);
        load(3, 5);
        load(8, 77);
        load(9, 99);
        load(15, 11);
        probe(0, 0, 0, 0);

        // Enter edit; preload ignored while editing
        bus_if.edit_req = 1'b1;
        cyc();
        probe(0, 0, 1, 0);
        load(0, 99);
        probe(0, 0, 1, 0);

        bus_if.limite = 7'd23;
        btn(0, 0, 1);
        probe(0, 23, 1, 0);

        btn(1, 0, 0);
        probe(1, 58, 1, 0);
        bus_if.limite = 7'd59;
        btn(0, 1, 0);
        probe(1, 59, 1, 0);
        btn(0, 1, 0);
        probe(1, 0, 1, 0);

        btn(1, 0, 0);
        probe(2, 30, 1, 0);
        bus_if.limite = 7'd23;
        btn(0, 0, 1);
        probe(2, 23, 1, 0);
        btn(0, 1, 1);
        probe(2, 23, 1, 0);
        // Edit hits old index (23 >= 23 -> 0), then index advances
        btn(1, 1, 0);
        probe(3, 5, 1, 0);

        repeat (6) btn(1, 0, 0);
        probe(0, 23, 1, 0);
        repeat (9) btn(1, 0, 0);
        probe(0, 23, 1, 0);

        // Commit, with edit_req raised mid-sweep (must be ignored)
        exp_f = '{23, 0, 0, 5, 0, 0, 0, 0, 77};
        push_writes(9);
        commit_q.push_back(1);
        bus_if.edit_req = 1'b0;
        repeat (3) cyc();
        bus_if.edit_req = 1'b1;
        repeat (5) cyc();
        bus_if.edit_req = 1'b0;
        wait_commit();
        probe(0, 23, 0, 0);

        // Commit aborted by reset after the 4th ack
        bus_if.edit_req = 1'b1;
        cyc();
        bus_if.edit_req = 1'b0;
        push_writes(5);
        base = ack_seen;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            cyc();
            got = (ack_seen >= base + 4);
        end
        chk("ack4_timeout", int'(got), 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("pending_writes_after_abort", wr_q.size(), 1);
        wr_q.delete();
        probe(0, 0, 0, 0);
        repeat (3) cyc();
        chk("commit_pulses_after_abort", commit_seen, 1);

        // Fields cleared by reset: full commit writes zeros except the new preload
        load(5, 100);
        exp_f = '{0, 0, 0, 0, 0, 100, 0, 0, 0};
        push_writes(9);
        commit_q.push_back(1);
        bus_if.edit_req = 1'b1;
        cyc();
        bus_if.edit_req = 1'b0;
        wait_commit();
        probe(0, 0, 0, 0);
        repeat (3) cyc();

        chk("commit_pulses_total", commit_seen, 2);
        chk("writes_left", wr_q.size(), 0);
        chk("commits_left", commit_q.size(), 0);
        chk("probes_left", probe_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
